// File: rtl/audio_sound_sequencer.sv
// Arbitrates engine/crash/game-over sounds onto one pwm_audio (AUDIO_SEQ_FADE_EN adds the game-over fade).
// Outputs are registered and follow the state register by one clk. Requests are sticky pulses; there is no backpressure.
module audio_sound_sequencer #(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int DUTY_CYCLE_WIDTH = 8,
    parameter int ENGINE_DUTY      = 128,
    parameter int CRASH_SPEED      = 200,
    parameter int CRASH_MS         = 300,
    parameter int GAMEOVER_MS      = 2000,
    parameter int FADE_STEP        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        engine_en,
    input  logic [7:0]                  engine_speed,
    input  logic                        crash_req,
    input  logic                        gameover_req,
    output logic [7:0]                  pwm_speed,
    output logic [DUTY_CYCLE_WIDTH-1:0] pwm_duty,
    output logic [1:0]                  grant,
    output logic                        busy,
    output logic                        done
);
    localparam int DW = DUTY_CYCLE_WIDTH;
    localparam logic [31:0]   TICK_LIM  = 32'(CLK_FREQUENCY_HZ / 1000 - 1);
    localparam logic [DW-1:0] DUTY_MAX  = '1;
    localparam logic [DW-1:0] ENG_DUTY  = DW'(ENGINE_DUTY);
    localparam logic [15:0]   CRASH_END = 16'(CRASH_MS);
    localparam logic [15:0]   GO_END    = 16'(GAMEOVER_MS);

`ifdef AUDIO_SEQ_FADE_EN
    localparam logic [DW:0]   FADE_DEC  = (DW+1)'(FADE_STEP);
    typedef enum logic [2:0] {S_IDLE, S_ENGINE, S_CRASH, S_GAMEOVER, S_FADE} state_t;
    logic [DW:0] fade_duty;
`else
    typedef enum logic [2:0] {S_IDLE, S_ENGINE, S_CRASH, S_GAMEOVER} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] div;
    logic        tick;
    logic [15:0] ms_cnt;
    logic        crash_pend, go_pend, mute;
    logic        finish, busy_now, crash_clr;
    logic [12:0] go_steps;
    logic [7:0]  go_speed;

    assign tick     = (div == TICK_LIM);
    assign busy_now = (state != S_IDLE) && (state != S_ENGINE);
    // game-over owns the channel until it ends, so crash requests meanwhile are dropped
    assign crash_clr = busy_now || (state_nxt == S_CRASH) || (state_nxt == S_GAMEOVER);
    assign go_steps = ms_cnt[15:3];
    assign go_speed = (go_steps >= 13'd255) ? 8'd0 : 8'(13'd255 - go_steps);

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_pend)                  state_nxt = S_GAMEOVER;
                else if (crash_pend)          state_nxt = S_CRASH;
                else if (engine_en && !mute)  state_nxt = S_ENGINE;
            end
            S_ENGINE: begin
                if (go_pend)                  state_nxt = S_GAMEOVER;
                else if (crash_pend)          state_nxt = S_CRASH;
                else if (!engine_en)          state_nxt = S_IDLE;
            end
            S_CRASH: begin
                if (go_pend) begin
                    state_nxt = S_GAMEOVER;
                end else if (ms_cnt == CRASH_END) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_GAMEOVER: begin
                if (ms_cnt == GO_END) begin
`ifdef AUDIO_SEQ_FADE_EN
                    state_nxt = S_FADE;
`else
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef AUDIO_SEQ_FADE_EN
            S_FADE: begin
                if (fade_duty == '0) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            div        <= '0;
            ms_cnt     <= '0;
            crash_pend <= 1'b0;
            go_pend    <= 1'b0;
            mute       <= 1'b0;
        end else begin
            state      <= state_nxt;
            div        <= tick ? 32'd0 : div + 32'd1;
            if (state_nxt != state)
                ms_cnt <= '0;
            else if (tick && ms_cnt != 16'hFFFF)
                ms_cnt <= ms_cnt + 16'd1;
            crash_pend <= crash_clr ? 1'b0 : (crash_pend | crash_req);
            go_pend    <= (state_nxt == S_GAMEOVER) ? 1'b0 : (go_pend | gameover_req);
            if (state == S_GAMEOVER)
                mute <= 1'b1;
        end
    end

`ifdef AUDIO_SEQ_FADE_EN
    always_ff @(posedge clk) begin
        if (reset)
            fade_duty <= '0;
        else if (state_nxt == S_FADE && state != S_FADE)
            fade_duty <= {1'b0, DUTY_MAX};
        else if (state == S_FADE && tick)
            fade_duty <= (fade_duty > FADE_DEC) ? fade_duty - FADE_DEC : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_speed <= '0;
            pwm_duty  <= '0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            busy <= busy_now;
            case (state)
                S_ENGINE: begin
                    grant     <= 2'b01;
                    pwm_duty  <= ENG_DUTY;
                    pwm_speed <= engine_speed;
                end
                S_CRASH: begin
                    grant     <= 2'b10;
                    pwm_duty  <= DUTY_MAX;
                    pwm_speed <= 8'(CRASH_SPEED);
                end
                S_GAMEOVER: begin
                    grant     <= 2'b11;
                    pwm_duty  <= finish ? '0 : DUTY_MAX;
                    pwm_speed <= go_speed;
                end
`ifdef AUDIO_SEQ_FADE_EN
                S_FADE: begin
                    grant     <= 2'b11;
                    pwm_duty  <= fade_duty[DW-1:0];
                end
`endif
                default: begin
                    grant     <= 2'b00;
                    pwm_duty  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_sound_sequencer.sv
// Self-checking bench for audio_sound_sequencer with 1 ms = 1 clk.
module tb_audio_sound_sequencer;
    localparam int CRASH_MS    = 300;
    localparam int GAMEOVER_MS = 2000;
    localparam int FADE_STEP   = 4;
    localparam int ENG_DUTY    = 128;
    localparam int CRASH_SPD   = 200;
`ifdef AUDIO_SEQ_FADE_EN
    localparam bit FADE_ON = 1'b1;
    localparam int GO_CYCLES = GAMEOVER_MS + 1 + (255 + FADE_STEP - 1) / FADE_STEP + 1;
`else
    localparam bit FADE_ON = 1'b0;
    localparam int GO_CYCLES = GAMEOVER_MS + 1;
`endif
    localparam int K_IDLE = 0, K_ENG = 1, K_CRASH = 2, K_GO = 3, K_FADE = 4;

    logic       clk = 1'b0;
    logic       reset, engine_en, crash_req, gameover_req;
    logic [7:0] engine_speed, pwm_speed, pwm_duty;
    logic [1:0] grant;
    logic       busy, done;

    audio_sound_sequencer #(
        .CLK_FREQUENCY_HZ(1000), .DUTY_CYCLE_WIDTH(8), .ENGINE_DUTY(ENG_DUTY),
        .CRASH_SPEED(CRASH_SPD), .CRASH_MS(CRASH_MS), .GAMEOVER_MS(GAMEOVER_MS),
        .FADE_STEP(FADE_STEP)
    ) dut (
        .clk(clk), .reset(reset), .engine_en(engine_en), .engine_speed(engine_speed),
        .crash_req(crash_req), .gameover_req(gameover_req), .pwm_speed(pwm_speed),
        .pwm_duty(pwm_duty), .grant(grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: which sound is playing, how many ms it has played, and the
    // registered outputs that the sound implies one clk later.
    int m_kind = K_IDLE, m_el = 0;
    bit m_cp = 0, m_gp = 0, m_mute = 0;
    int x_grant = 0, x_duty = 0, x_speed = 0, x_busy = 0, x_done = 0;

    task automatic model_step(input bit rst, input bit en, input int spd, input bit cr, input bit go);
        int nk, lvl;
        bit fin;
        if (rst) begin
            m_kind = K_IDLE; m_el = 0; m_cp = 0; m_gp = 0; m_mute = 0;
            x_grant = 0; x_duty = 0; x_speed = 0; x_busy = 0; x_done = 0;
            return;
        end
        nk  = m_kind;
        fin = 0;
        lvl = 255 - FADE_STEP * m_el;
        if (lvl < 0) lvl = 0;
        case (m_kind)
            K_IDLE:  nk = m_gp ? K_GO : m_cp ? K_CRASH : (en && !m_mute) ? K_ENG : K_IDLE;
            K_ENG:   nk = m_gp ? K_GO : m_cp ? K_CRASH : !en ? K_IDLE : K_ENG;
            K_CRASH: if (m_gp) nk = K_GO;
                     else if (m_el == CRASH_MS) begin fin = 1; nk = K_IDLE; end
            K_GO:    if (m_el == GAMEOVER_MS) begin
                         if (FADE_ON) nk = K_FADE;
                         else begin fin = 1; nk = K_IDLE; end
                     end
            default: if (lvl == 0) begin fin = 1; nk = K_IDLE; end
        endcase
        x_done = fin;
        x_busy = (m_kind >= K_CRASH);
        case (m_kind)
            K_IDLE:  begin x_grant = 0; x_duty = 0; end
            K_ENG:   begin x_grant = 1; x_duty = ENG_DUTY; x_speed = spd; end
            K_CRASH: begin x_grant = 2; x_duty = 255; x_speed = CRASH_SPD; end
            K_GO:    begin
                x_grant = 3; x_duty = fin ? 0 : 255;
                x_speed = (255 - m_el / 8 < 0) ? 0 : 255 - m_el / 8;
            end
            default: begin x_grant = 3; x_duty = lvl; end
        endcase
        m_cp = (m_kind >= K_CRASH || nk == K_CRASH || nk == K_GO) ? 1'b0 : (m_cp | cr);
        m_gp = (nk == K_GO) ? 1'b0 : (m_gp | go);
        if (m_kind == K_GO) m_mute = 1;
        m_el   = (nk != m_kind) ? 0 : m_el + 1;
        m_kind = nk;
    endtask

    task automatic step(input bit rst, input bit en, input logic [7:0] spd, input bit cr, input bit go);
        reset = rst; engine_en = en; engine_speed = spd; crash_req = cr; gameover_req = go;
        @(posedge clk);
        model_step(rst, en, int'(spd), cr, go);
        #1;
        check("grant", int'(grant), x_grant);
        check("pwm_duty", int'(pwm_duty), x_duty);
        check("pwm_speed", int'(pwm_speed), x_speed);
        check("busy", int'(busy), x_busy);
        check("done", int'(done), x_done);
    endtask

    typedef struct {
        bit rst; bit en; logic [7:0] spd;
        int g; int d; int s;
    } vec_t;

    initial begin
        vec_t vt[7];
        int n_a, n_b, n_dn;
        bit seen;
        bit r_en;

        // Engine on/off and reset, one row per clk.
        vt[0] = '{1, 0, 8'd0,  0, 0,   0};
        vt[1] = '{0, 1, 8'd50, 0, 0,   0};
        vt[2] = '{0, 1, 8'd50, 1, 128, 50};
        vt[3] = '{0, 1, 8'd77, 1, 128, 77};
        vt[4] = '{0, 0, 8'd77, 1, 128, 77};
        vt[5] = '{0, 0, 8'd77, 0, 0,   77};
        vt[6] = '{1, 1, 8'd77, 0, 0,   0};
        for (int i = 0; i < 7; i++) begin
            step(vt[i].rst, vt[i].en, vt[i].spd, 0, 0);
            check($sformatf("vec%0d_grant", i), int'(grant), vt[i].g);
            check($sformatf("vec%0d_duty", i), int'(pwm_duty), vt[i].d);
            check($sformatf("vec%0d_speed", i), int'(pwm_speed), vt[i].s);
        end

        // Crash over a running engine, then engine resumes.
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 8'd60, 0, 0);
        step(0, 1, 8'd60, 1, 0);
        n_a = 0; n_dn = 0; seen = 0;
        for (int i = 0; i < 500; i++) begin
            step(0, 1, 8'd60, 0, 0);
            if (grant == 2'b10) n_a++;
            if (done) n_dn++;
            if (n_a > 0 && grant == 2'b01) begin seen = 1; break; end
        end
        check("crash_back_to_engine", int'(seen), 1);
        check("crash_len", n_a, CRASH_MS + 1);
        check("crash_done_cnt", n_dn, 1);

        // Simultaneous requests: game-over only, then muted engine.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        n_a = 0; n_b = 0; n_dn = 0; seen = 0;
        for (int i = 0; i < 3000; i++) begin
            step(0, 0, 0, 0, 0);
            if (grant == 2'b11) n_a++;
            if (grant == 2'b10) n_b++;
            if (done) n_dn++;
            if (n_a > 0 && grant == 2'b00) begin seen = 1; break; end
        end
        check("go_finished", int'(seen), 1);
        check("go_len", n_a, GO_CYCLES);
        check("go_no_crash", n_b, 0);
        check("go_done_cnt", n_dn, 1);
        repeat (10) step(0, 1, 8'd90, 0, 0);
        check("mute_grant", int'(grant), 0);
        check("mute_duty", int'(pwm_duty), 0);

        // Game-over preempting a crash 100 ms in.
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 1, 8'd40, 0, 0);
        step(0, 1, 8'd40, 1, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 1, 8'd40, 0, 0);
            seen = (grant == 2'b10);
        end
        check("crash_started", int'(seen), 1);
        n_dn = 0;
        repeat (99) begin step(0, 1, 8'd40, 0, 0); if (done) n_dn++; end
        step(0, 1, 8'd40, 0, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 1, 8'd40, 0, 0);
            if (done) n_dn++;
            seen = (grant == 2'b11);
        end
        check("preempt_grant", int'(seen), 1);
        check("preempt_no_done", n_dn, 0);
        repeat (100) step(0, 1, 8'd40, 0, 0);
        check("go_speed_100ms", int'(pwm_speed), 243);

        // Reset in the middle of game-over clears mute.
        step(1, 1, 8'd40, 0, 0);
        check("rst_speed", int'(pwm_speed), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        repeat (3) step(0, 1, 8'd40, 0, 0);
        check("unmute_grant", int'(grant), 1);
        check("unmute_duty", int'(pwm_duty), ENG_DUTY);

        // Random traffic against the reference.
        r_en = 0;
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(49) == 0) r_en = ~r_en;
            step($urandom_range(1499) == 0, r_en, 8'($urandom_range(255)),
                 $urandom_range(199) == 0, $urandom_range(2999) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
